// File: rtl/bc_sched_pkg.sv
// Shared types and helpers for the box-count pass sequencer and its neighbours.
// Address layout of a finest-level box is {x, 1'b0, y}.
package bc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL_A,
        FILL_B,
        COARSEN,
        DONE
    } state_t;

    function automatic int addr_w(input int box_idx);
        return 2 * box_idx + 1;
    endfunction

    // Finest-level box address; callers truncate to their address width.
    function automatic logic [31:0] fine_addr(input logic [31:0] x,
                                              input logic [31:0] y,
                                              input int box_idx);
        return (x << (box_idx + 1)) | y;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit word.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_val;
        max_val = (32'd1 << w) - 32'd1;
        return (v >= max_val) ? max_val : v + 32'd1;
    endfunction

endpackage

// File: rtl/bc_sched_port_mux.sv
// BC RAM port selection: the coarsening engine owns both ports during COARSEN,
// the sequencer owns them otherwise.
module bc_port_mux
    import bc_sched_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_LEN = 8
) (
    input  state_t              state,
    input  logic [ADDR_W-1:0]   ctl_raddr,
    input  logic [ADDR_W-1:0]   ctl_waddr,
    input  logic                ctl_wen,
    input  logic [DATA_LEN-1:0] ctl_wdata,
    input  logic [ADDR_W-1:0]   sqg_rd_addr,
    input  logic [ADDR_W-1:0]   sqg_wr_addr,
    input  logic                sqg_wen,
    input  logic [DATA_LEN-1:0] sqg_y,
    output logic [ADDR_W-1:0]   ram_raddr,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic                ram_wen,
    output logic [DATA_LEN-1:0] ram_wdata,
    output logic                bc_mode
);

    logic engine_sel;

    assign engine_sel = (state == COARSEN);
    assign bc_mode    = ~engine_sel;

    assign ram_raddr = engine_sel ? sqg_rd_addr : ctl_raddr;
    assign ram_waddr = engine_sel ? sqg_wr_addr : ctl_waddr;
    assign ram_wen   = engine_sel ? sqg_wen     : ctl_wen;
    assign ram_wdata = engine_sel ? sqg_y       : ctl_wdata;

endmodule

// File: rtl/bc_sched.sv
// One box-count pass: clear the BC RAM, accumulate pixel hits with a two-cycle
// read-modify-write, then lend the RAM to the coarsening engine for a fixed window.
module bc_sched
    import bc_sched_pkg::*;
#(
    parameter int BOX_IDX        = 3,
    parameter int DATA_LEN       = 8,
    parameter int COARSEN_CYCLES = 85,
    localparam int ADDR_W        = addr_w(BOX_IDX)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                pix_valid,
    input  logic [BOX_IDX-1:0]  pix_x,
    input  logic [BOX_IDX-1:0]  pix_y,
    input  logic                pix_last,
    output logic                pix_ready,
    output logic                bc_mode,
    input  logic [ADDR_W-1:0]   sqg_rd_addr,
    input  logic [ADDR_W-1:0]   sqg_wr_addr,
    input  logic                sqg_wen,
    input  logic [DATA_LEN-1:0] sqg_y,
    output logic [DATA_LEN-1:0] sqg_x,
    output logic [ADDR_W-1:0]   ram_raddr,
    input  logic [DATA_LEN-1:0] ram_rdata,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic                ram_wen,
    output logic [DATA_LEN-1:0] ram_wdata,
    output logic                busy,
    output logic                done
);

    localparam int CC_W = $clog2(COARSEN_CYCLES + 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [CC_W-1:0]     co_cnt_reg, co_cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                last_reg, last_next;

    logic [ADDR_W-1:0]   hit_addr;
    logic [DATA_LEN-1:0] inc_data;
    logic [ADDR_W-1:0]   ctl_raddr, ctl_waddr;
    logic                ctl_wen;
    logic [DATA_LEN-1:0] ctl_wdata;

    assign hit_addr = ADDR_W'(fine_addr(32'(pix_x), 32'(pix_y), BOX_IDX));
    assign inc_data = DATA_LEN'(sat_inc(32'(ram_rdata), DATA_LEN));
    assign sqg_x    = ram_rdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            clr_cnt_reg <= '0;
            co_cnt_reg  <= '0;
            addr_reg    <= '0;
            last_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            co_cnt_reg  <= co_cnt_next;
            addr_reg    <= addr_next;
            last_reg    <= last_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        co_cnt_next  = co_cnt_reg;
        addr_next    = addr_reg;
        last_next    = last_reg;
        pix_ready    = 1'b0;
        busy         = (state_reg != IDLE);
        done         = 1'b0;
        ctl_raddr    = '0;
        ctl_waddr    = '0;
        ctl_wen      = 1'b0;
        ctl_wdata    = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                ctl_wen   = 1'b1;
                ctl_waddr = clr_cnt_reg;
                if (&clr_cnt_reg) begin
                    state_next = FILL_A;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            FILL_A: begin
                // Read is issued on the handshake cycle; data arrives in FILL_B.
                pix_ready = 1'b1;
                ctl_raddr = hit_addr;
                if (pix_valid) begin
                    addr_next  = hit_addr;
                    last_next  = pix_last;
                    state_next = FILL_B;
                end
            end
            FILL_B: begin
                ctl_wen   = 1'b1;
                ctl_waddr = addr_reg;
                ctl_wdata = inc_data;
                if (last_reg) begin
                    state_next  = COARSEN;
                    co_cnt_next = CC_W'(COARSEN_CYCLES - 1);
                end else begin
                    state_next = FILL_A;
                end
            end
            COARSEN: begin
                if (co_cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    co_cnt_next = co_cnt_reg - 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    bc_port_mux #(
        .ADDR_W   (ADDR_W),
        .DATA_LEN (DATA_LEN)
    ) u_port_mux (
        .state       (state_reg),
        .ctl_raddr   (ctl_raddr),
        .ctl_waddr   (ctl_waddr),
        .ctl_wen     (ctl_wen),
        .ctl_wdata   (ctl_wdata),
        .sqg_rd_addr (sqg_rd_addr),
        .sqg_wr_addr (sqg_wr_addr),
        .sqg_wen     (sqg_wen),
        .sqg_y       (sqg_y),
        .ram_raddr   (ram_raddr),
        .ram_waddr   (ram_waddr),
        .ram_wen     (ram_wen),
        .ram_wdata   (ram_wdata),
        .bc_mode     (bc_mode)
    );

endmodule

// File: tb/tb_bc_sched.sv
// Directed bench for bc_sched with a behavioural BC RAM and a write scoreboard.
module tb_bc_sched;

    localparam int BI = 3;
    localparam int DL = 8;
    localparam int CC = 85;
    localparam int AW = 2 * BI + 1;
    localparam int NW = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          pix_valid;
    logic [BI-1:0] pix_x, pix_y;
    logic          pix_last;
    logic          pix_ready;
    logic          bc_mode;
    logic [AW-1:0] sqg_rd_addr, sqg_wr_addr;
    logic          sqg_wen;
    logic [DL-1:0] sqg_y, sqg_x;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DL-1:0] ram_rdata, ram_wdata;
    logic          ram_wen;
    logic          busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+DL-1:0] exp_q[$];
    int model[NW];
    logic [DL-1:0] mem[NW];

    bc_sched #(.BOX_IDX(BI), .DATA_LEN(DL), .COARSEN_CYCLES(CC)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .pix_ready(pix_ready), .bc_mode(bc_mode),
        .sqg_rd_addr(sqg_rd_addr), .sqg_wr_addr(sqg_wr_addr), .sqg_wen(sqg_wen),
        .sqg_y(sqg_y), .sqg_x(sqg_x),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr),
        .ram_wen(ram_wen), .ram_wdata(ram_wdata), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // 1R1W RAM with one-cycle registered read.
    always @(posedge CLK) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller-owned writes are popped from the scoreboard in order.
    task automatic monitor();
        logic [AW+DL-1:0] e;
        if (ram_wen === 1'b1 && bc_mode === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'({ram_waddr, ram_wdata}), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("ram_write", 32'({ram_waddr, ram_wdata}), 32'(e));
                $display("write addr=0x%02h data=0x%02h", ram_waddr, ram_wdata);
            end
        end
    endtask

    task automatic to_neg();
        @(negedge CLK);
        monitor();
    endtask

    task automatic to_pos();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pass(input bit hold);
        start = 1'b1;
        to_neg();
        chk("busy_before_start", 32'(busy), 32'd0);
        to_pos();
        if (!hold) start = 1'b0;
        for (int a = 0; a < NW; a++) begin
            model[a] = 0;
            exp_q.push_back({AW'(a), DL'(0)});
        end
        for (int a = 0; a < NW; a++) begin
            to_neg();
            chk("clear_wen", 32'(ram_wen), 32'd1);
            if (a == 0) chk("busy_after_start", 32'(busy), 32'd1);
            to_pos();
        end
    endtask

    task automatic send_hit(input logic [BI-1:0] x, input logic [BI-1:0] y, input bit last);
        logic [AW-1:0] a;
        bit got;
        got = 1'b0;
        a = {x, 1'b0, y};
        pix_valid = 1'b1;
        pix_x = x;
        pix_y = y;
        pix_last = last;
        for (int n = 0; n < 50 && !got; n++) begin
            to_neg();
            if (n == 0) chk("ready_phase_a", 32'(pix_ready), 32'd1);
            if (pix_ready === 1'b1) begin
                got = 1'b1;
                model[a] = (model[a] < 255) ? model[a] + 1 : 255;
                exp_q.push_back({a, DL'(model[a])});
            end
            to_pos();
        end
        if (!got) chk("ready_timeout", 32'(got), 32'd1);
        pix_valid = 1'b0;
        pix_last = 1'b0;
        pix_x = BI'($urandom_range(7));
        pix_y = BI'($urandom_range(7));
        to_neg();
        chk("ready_phase_b", 32'(pix_ready), 32'd0);
        to_pos();
    endtask

    // Returns at the negedge of the IDLE cycle after DONE, or at the rst_at-th engine cycle.
    task automatic wait_coarsen(input int rst_at);
        int low;
        bit fin;
        low = 0;
        fin = 1'b0;
        for (int n = 0; n < 300 && !fin; n++) begin
            to_neg();
            if (bc_mode === 1'b0) begin
                low++;
                if (low == 1) begin
                    chk("mux_raddr", 32'(ram_raddr), 32'h33);
                    chk("mux_waddr", 32'(ram_waddr), 32'h08);
                    chk("mux_wen", 32'(ram_wen), 32'd1);
                    chk("mux_wdata", 32'(ram_wdata), 32'h11);
                    chk("sqg_x", 32'(sqg_x), 32'(ram_rdata));
                    chk("busy_coarsen", 32'(busy), 32'd1);
                end
                if (low == rst_at) fin = 1'b1;
                else to_pos();
            end else if (low > 0) begin
                chk("coarsen_len", 32'(low), 32'(CC));
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_in_done", 32'(busy), 32'd1);
                to_pos();
                to_neg();
                chk("done_clear", 32'(done), 32'd0);
                chk("busy_idle", 32'(busy), 32'd0);
                fin = 1'b1;
            end else begin
                to_pos();
            end
        end
        if (!fin) chk("coarsen_timeout", 32'(fin), 32'd1);
    endtask

    task automatic rst_check(input string where);
        chk({"sb_empty_", where}, 32'(exp_q.size()), 32'd0);
        #1;
        RST = 1'b1;
        #1;
        chk({"rst_bc_mode_", where}, 32'(bc_mode), 32'd1);
        chk({"rst_busy_", where}, 32'(busy), 32'd0);
        chk({"rst_ready_", where}, 32'(pix_ready), 32'd0);
        chk({"rst_wen_", where}, 32'(ram_wen), 32'd0);
        chk({"rst_raddr_", where}, 32'(ram_raddr), 32'd0);
        chk({"rst_waddr_", where}, 32'(ram_waddr), 32'd0);
        chk({"rst_wdata_", where}, 32'(ram_wdata), 32'd0);
        chk({"rst_done_", where}, 32'(done), 32'd0);
        $display("reset applied %s", where);
        exp_q.delete();
        to_pos();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_x = '0;
        pix_y = '0;
        pix_last = 1'b0;
        sqg_rd_addr = 7'h33;
        sqg_wr_addr = 7'h08;
        sqg_wen = 1'b1;
        sqg_y = 8'h11;

        #12;
        chk("reset_bc_mode", 32'(bc_mode), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(pix_ready), 32'd0);
        chk("reset_wen", 32'(ram_wen), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_raddr", 32'(ram_raddr), 32'd0);
        to_pos();
        RST = 1'b0;

        // Clear, three hits, coarsening window, done.
        start_pass(1'b0);
        send_hit(3'd2, 3'd5, 1'b0);
        send_hit(3'd2, 3'd5, 1'b0);
        send_hit(3'd7, 3'd0, 1'b1);
        wait_coarsen(0);
        to_pos();

        // Saturation of one box.
        start_pass(1'b0);
        for (int i = 0; i < 300; i++) send_hit(3'd0, 3'd0, i == 299);
        chk("sat_model", 32'(model[0]), 32'd255);
        wait_coarsen(0);
        to_pos();

        // Reset mid-FILL, then mid-COARSEN.
        start_pass(1'b0);
        send_hit(3'd3, 3'd3, 1'b0);
        send_hit(3'd1, 3'd6, 1'b0);
        rst_check("fill");
        start_pass(1'b0);
        send_hit(3'd4, 3'd1, 1'b1);
        wait_coarsen(20);
        rst_check("coarsen");

        // start held high: one full pass, then a new clear right after IDLE.
        start_pass(1'b1);
        send_hit(3'd5, 3'd2, 1'b0);
        send_hit(3'd6, 3'd7, 1'b1);
        wait_coarsen(0);
        exp_q.push_back({AW'(0), DL'(0)});
        to_pos();
        to_neg();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_wen", 32'(ram_wen), 32'd1);
        start = 1'b0;
        to_pos();
        rst_check("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
